ddr2_write_arbiter: RTL and testbench
=====================================

Name: ddr2_write_arbiter

Overview:
- Shares the single DDR2 write path (address FIFO and write-data FIFO) between three write requesters: 0 = frame filler, 1 = line engine, 2 = CPU/cache writeback.
- Grants the path to one requester at a time using round-robin order, and muxes the granted requester's address, data and mask onto the FIFOs.
- Returns gated full signals to each requester. Non-granted requesters always see full.
- Switches owner only at command boundaries, where every address entry has its full set of data words.

Parameters:
- WDF_PER_AF, 2: write-data words required per address-FIFO command (supported range 1..4).
- MAX_HOLD, 64: accepted address commands after which the owner must yield if another requester is waiting (range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  3  per-requester write request, level; bit i belongs to requester i
- rq_af_addr  in  93  packed 3x31 addresses; requester i uses [31i+30:31i]
- rq_af_wr_en  in  3  per-requester address write enable
- rq_wdf_din  in  384  packed 3x128 write data
- rq_wdf_mask  in  48  packed 3x16 byte masks
- rq_wdf_wr_en  in  3  per-requester data write enable
- rq_af_full  out  3  gated address-FIFO full, per requester
- rq_wdf_full  out  3  gated data-FIFO full, per requester
- grant  out  3  one-hot current owner; 000 when no owner
- af_full  in  1  DDR2 address FIFO full
- wdf_full  in  1  DDR2 data FIFO full
- af_addr_din  out  31  muxed address
- af_wr_en  out  1  address FIFO write
- wdf_din  out  128  muxed data
- wdf_mask_din  out  16  muxed mask
- wdf_wr_en  out  1  data FIFO write

Behaviour:
- States:
  - IDLE: no owner.
  - OWN: owner may issue address commands and data words.
  - DRAIN: owner may issue data words only.
- Reset values:
  - State IDLE, grant=000, rr pointer=0, hold_cnt=0, bal=0.
  - af_wr_en=0, wdf_wr_en=0; rq_af_full=111, rq_wdf_full=111.
- IDLE:
  - If req≠0, grant the first requesting index at or after the rr pointer, searching upward modulo 3; go to OWN.
  - Grant registers on the clock edge, so grant is visible 1 cycle after req is sampled.
  - Clear hold_cnt and bal on entry to OWN.
- Accept conditions:
  - Address accept: acc_af = owner's rq_af_wr_en & ~af_full & af permitted. Address writes are permitted only in OWN.
  - Data accept: acc_wdf = owner's rq_wdf_wr_en & ~wdf_full. Data writes are permitted in OWN and DRAIN.
  - af_wr_en=acc_af and wdf_wr_en=acc_wdf, combinational, same cycle.
  - Address, data and mask outputs are muxed from the owner and are don't-care when no owner.
- Gated full signals:
  - Owner: rq_af_full = af_full | ~(state==OWN); rq_wdf_full = wdf_full.
  - Non-owners: both full signals forced to 1.
- Balance counter bal (signed, 4 bits):
  - bal += WDF_PER_AF on acc_af; bal -= 1 on acc_wdf; a simultaneous accept applies both.
  - Data may lead the address by at most WDF_PER_AF words. If the owner attempts to exceed this, the arbiter holds rq_wdf_full high for it.
- hold_cnt (8 bits): increments on acc_af and saturates at 255.
- Release condition (evaluated in OWN):
  - The owner's req is low, or
  - hold_cnt ≥ MAX_HOLD and some other req bit is high.
- On release:
  - If bal==0 after this cycle's updates, go to IDLE.
  - Otherwise go to DRAIN.
- DRAIN: go to IDLE on the cycle after bal reaches 0.
- On leaving for IDLE: grant becomes 000 and the rr pointer becomes owner+1 mod 3.
- Minimum switch gap is 1 IDLE cycle, so the next grant appears 2 cycles after the release cycle.
- An owner that drops req with bal≠0 is an error case: the arbiter stays in DRAIN and keeps granting data writes until the balance closes.
- Full FIFOs do not affect state transitions; writes simply stall.
- Reset mid-operation: all state returns to reset values the next cycle and any in-flight balance is discarded.

Test Plan:
- Single requester: req=001, 4 commands each with 2 data words, no back-pressure → grant=001 one cycle after req; af_wr_en pulses 4 times, wdf_wr_en 8 times; req drop → IDLE, grant=000, rq_*_full=111.
- Round-robin: req=111 held, MAX_HOLD=2, each requester continuously issues commands → owners cycle 0,1,2,0; exactly 2 address commands per tenure; one IDLE cycle between tenures.
- Switch at boundary: owner 1 issues an address command, then drops req before its 2nd data word → DRAIN; rq_af_full[1]=1 while rq_wdf_full[1]=0; the 2nd data word is accepted; IDLE next cycle, then grant moves to the waiting requester.
- Back-pressure: af_full=1 for 5 cycles while the owner asserts rq_af_wr_en → af_wr_en=0 and rq_af_full[owner]=1 for those cycles; hold_cnt unchanged; resumes when af_full falls.
- Data lead limit: owner writes 3 data words before any address with WDF_PER_AF=2 → the 3rd word is blocked (rq_wdf_full=1, wdf_wr_en=0) until the address is accepted.
- Reset during OWN with bal=1 → next cycle grant=000, all rq_*_full=1, rr pointer=0; req=010 then yields grant=010.

Source files
------------

// File: rtl/ddr2_write_arbiter.sv
// ddr2_write_arbiter: round-robin share of the DDR2 address/data write FIFOs among three requesters (ports: clk, rst, req, rq_* requester side, grant, af_*/wdf_* FIFO side)
module ddr2_write_arbiter #(
  parameter int WDF_PER_AF = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [92:0]  rq_af_addr,
  input  logic [2:0]   rq_af_wr_en,
  input  logic [383:0] rq_wdf_din,
  input  logic [47:0]  rq_wdf_mask,
  input  logic [2:0]   rq_wdf_wr_en,
  output logic [2:0]   rq_af_full,
  output logic [2:0]   rq_wdf_full,
  output logic [2:0]   grant,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en
);
  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
  state_t state;
  logic [1:0] own, rr, pick, i1, i2;
  logic [7:0] hold, hold_nx;
  logic [3:0] bal, bal_nx;
  logic lead, af_ok, acc_af, acc_wdf, rel;
  always_comb begin
    i1 = rr == 2'd2 ? 2'd0 : rr + 2'd1;
    i2 = rr == 2'd0 ? 2'd2 : rr - 2'd1;
    pick = req[rr] ? rr : req[i1] ? i1 : i2;
    lead = bal == 4'(-WDF_PER_AF);
    af_ok = bal[3] | ({1'b0, bal} + 5'(WDF_PER_AF) <= 5'd7);
    acc_af = state == OWN && rq_af_wr_en[own] && !af_full && af_ok;
    acc_wdf = state != IDLE && rq_wdf_wr_en[own] && !wdf_full && !lead;
    bal_nx = bal + (acc_af ? 4'(WDF_PER_AF) : 4'd0) - {3'd0, acc_wdf};
    hold_nx = (acc_af && hold != 8'hff) ? hold + 8'd1 : hold;
    rel = state == OWN && (!req[own] || (hold_nx >= 8'(MAX_HOLD) && |(req & ~grant)));
  end
  assign af_wr_en = acc_af;
  assign wdf_wr_en = acc_wdf;
  assign rq_af_full = ~grant | {3{af_full || state != OWN || !af_ok}};
  assign rq_wdf_full = ~grant | {3{wdf_full || lead}};
  assign af_addr_din = rq_af_addr[31*own +: 31];
  assign wdf_din = rq_wdf_din[128*own +: 128];
  assign wdf_mask_din = rq_wdf_mask[16*own +: 16];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 3'b000;
      own <= 2'd0;
      rr <= 2'd0;
      hold <= 8'd0;
      bal <= 4'd0;
    end else if (state == IDLE) begin
      if (|req) begin
        state <= OWN;
        own <= pick;
        grant <= 3'b001 << pick;
        hold <= 8'd0;
        bal <= 4'd0;
      end
    end else begin
      hold <= hold_nx;
      bal <= bal_nx;
      if (rel || state == DRAIN) begin
        if (bal_nx == 4'd0) begin
          state <= IDLE;
          grant <= 3'b000;
          rr <= own == 2'd2 ? 2'd0 : own + 2'd1;
        end else state <= DRAIN;
      end
    end
  end
endmodule

// File: tb/tb_ddr2_write_arbiter.sv
// tb_ddr2_write_arbiter: scoreboard bench for ddr2_write_arbiter with directed cycle vectors
module tb_ddr2_write_arbiter;
  logic clk = 0, rst = 1;
  logic [2:0] req = 0, rq_af_wr_en = 0, rq_wdf_wr_en = 0;
  logic [92:0] rq_af_addr = 0;
  logic [383:0] rq_wdf_din = 0;
  logic [47:0] rq_wdf_mask = 0;
  logic [2:0] rq_af_full, rq_wdf_full, grant;
  logic af_full = 0, wdf_full = 0;
  logic [30:0] af_addr_din;
  logic af_wr_en, wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0] wdf_mask_din;
  int checks = 0, errors = 0;
  int aseq [3] = '{100, 200, 300};
  int dseq [3] = '{10, 20, 30};
  logic [30:0] exp_af [$];
  logic [143:0] exp_wd [$];

  ddr2_write_arbiter #(.WDF_PER_AF(2), .MAX_HOLD(2)) dut (
    .clk(clk), .rst(rst), .req(req), .rq_af_addr(rq_af_addr), .rq_af_wr_en(rq_af_wr_en),
    .rq_wdf_din(rq_wdf_din), .rq_wdf_mask(rq_wdf_mask), .rq_wdf_wr_en(rq_wdf_wr_en),
    .rq_af_full(rq_af_full), .rq_wdf_full(rq_wdf_full), .grant(grant), .af_full(af_full),
    .wdf_full(wdf_full), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .wdf_din(wdf_din),
    .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [143:0] a, input logic [143:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (af_wr_en) begin
      if (exp_af.size() == 0) chk("af_unexpected", 144'(af_addr_din), 144'h0);
      else chk("af_addr", 144'(af_addr_din), 144'(exp_af.pop_front()));
    end
    if (wdf_wr_en) begin
      if (exp_wd.size() == 0) chk("wdf_unexpected", {wdf_mask_din, wdf_din}, 144'h0);
      else chk("wdf_data", {wdf_mask_din, wdf_din}, exp_wd.pop_front());
    end
  end

  // one cycle: drive, push expected writes of owner eg, check grant/fulls at negedge
  task automatic tick(input logic [2:0] r, input logic [2:0] af, input logic [2:0] wd,
                      input logic [2:0] eg, input logic [2:0] efa, input logic [2:0] efw,
                      input logic ea, input logic ew);
    int o;
    o = eg[1] ? 1 : eg[2] ? 2 : 0;
    req = r;
    rq_af_wr_en = af;
    rq_wdf_wr_en = wd;
    for (int i = 0; i < 3; i++) begin
      rq_af_addr[31*i +: 31] = {2'(i), 29'(aseq[i])};
      rq_wdf_din[128*i +: 128] = {8'(i), 120'(dseq[i])};
      rq_wdf_mask[16*i +: 16] = {4'(i), 12'(dseq[i])};
    end
    if (ea) begin
      exp_af.push_back({2'(o), 29'(aseq[o])});
      aseq[o]++;
    end
    if (ew) begin
      exp_wd.push_back({4'(o), 12'(dseq[o]), 8'(o), 120'(dseq[o])});
      dseq[o]++;
    end
    @(negedge clk);
    chk("grant", 144'(grant), 144'(eg));
    chk("rq_af_full", 144'(rq_af_full), 144'(efa));
    chk("rq_wdf_full", 144'(rq_wdf_full), 144'(efw));
    @(posedge clk);
    #1;
  endtask

  task automatic drained(input string n);
    chk({n, "_af_left"}, 144'(exp_af.size()), 144'h0);
    chk({n, "_wd_left"}, 144'(exp_wd.size()), 144'h0);
  endtask

  task automatic do_reset;
    rst = 1;
    req = 0;
    rq_af_wr_en = 0;
    rq_wdf_wr_en = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    logic [2:0] g, n;
    do_reset();
    tick(3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0);
    // single requester: 4 commands with 2 words each
    tick(3'b001, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick(3'b001, 3'b111, 3'b111, 3'b001, 3'b110, 3'b110, 1, 1);
      tick(3'b001, 3'b000, 3'b111, 3'b001, 3'b110, 3'b110, 0, 1);
    end
    tick(3'b000, 3'b000, 3'b000, 3'b001, 3'b110, 3'b110, 0, 0);
    tick(3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0);
    drained("single");
    // round robin, MAX_HOLD=2: owners 0,1,2,0 with two commands each
    do_reset();
    tick(3'b111, 3'b111, 3'b111, 3'b000, 3'b111, 3'b111, 0, 0);
    for (int k = 0; k < 4; k++) begin
      g = 3'b001 << (k % 3);
      n = ~g;
      tick(3'b111, 3'b111, 3'b111, g, n, n, 1, 1);
      tick(3'b111, 3'b000, 3'b111, g, n, n, 0, 1);
      tick(3'b111, 3'b111, 3'b111, g, n, n, 1, 1);
      tick(3'b111, 3'b000, 3'b111, g, 3'b111, n, 0, 1);
      tick(k == 3 ? 3'b000 : 3'b111, 3'b111, 3'b111, 3'b000, 3'b111, 3'b111, 0, 0);
    end
    drained("rr");
    // switch at boundary: owner 1 drops req with one word outstanding
    tick(3'b110, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0);
    tick(3'b110, 3'b111, 3'b111, 3'b010, 3'b101, 3'b101, 1, 1);
    tick(3'b100, 3'b000, 3'b000, 3'b010, 3'b101, 3'b101, 0, 0);
    tick(3'b100, 3'b111, 3'b111, 3'b010, 3'b111, 3'b101, 0, 1);
    tick(3'b100, 3'b111, 3'b111, 3'b000, 3'b111, 3'b111, 0, 0);
    tick(3'b100, 3'b000, 3'b000, 3'b100, 3'b011, 3'b011, 0, 0);
    drained("boundary");
    // back-pressure on owner 2 with requester 0 waiting; hold count must not move
    af_full = 1;
    repeat (5) tick(3'b101, 3'b111, 3'b000, 3'b100, 3'b111, 3'b011, 0, 0);
    af_full = 0;
    tick(3'b101, 3'b111, 3'b111, 3'b100, 3'b011, 3'b011, 1, 1);
    tick(3'b101, 3'b000, 3'b111, 3'b100, 3'b011, 3'b011, 0, 1);
    tick(3'b101, 3'b111, 3'b111, 3'b100, 3'b011, 3'b011, 1, 1);
    tick(3'b101, 3'b000, 3'b111, 3'b100, 3'b111, 3'b011, 0, 1);
    tick(3'b001, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0);
    drained("backpressure");
    // data lead limit: third word ahead of the address is held off
    tick(3'b001, 3'b000, 3'b111, 3'b001, 3'b110, 3'b110, 0, 1);
    tick(3'b001, 3'b000, 3'b111, 3'b001, 3'b110, 3'b110, 0, 1);
    tick(3'b001, 3'b000, 3'b111, 3'b001, 3'b110, 3'b111, 0, 0);
    tick(3'b001, 3'b111, 3'b111, 3'b001, 3'b110, 3'b111, 1, 0);
    tick(3'b001, 3'b000, 3'b111, 3'b001, 3'b110, 3'b110, 0, 1);
    tick(3'b001, 3'b111, 3'b111, 3'b001, 3'b110, 3'b110, 1, 1);
    tick(3'b000, 3'b000, 3'b000, 3'b001, 3'b110, 3'b110, 0, 0);
    tick(3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0);
    drained("lead");
    // reset during OWN with one word outstanding; rr pointer back to 0
    tick(3'b001, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0);
    tick(3'b001, 3'b111, 3'b111, 3'b001, 3'b110, 3'b110, 1, 1);
    rst = 1;
    tick(3'b001, 3'b000, 3'b000, 3'b001, 3'b110, 3'b110, 0, 0);
    rst = 0;
    tick(3'b101, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0);
    tick(3'b000, 3'b000, 3'b000, 3'b001, 3'b110, 3'b110, 0, 0);
    tick(3'b010, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0);
    tick(3'b010, 3'b000, 3'b000, 3'b010, 3'b101, 3'b101, 0, 0);
    drained("reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
